// File: rtl/mdr_host_sequencer_if.sv
// Bundle of the command/response handshake and the MDR operand-loading bus.
// The master modport is the sequencer's view; slave is the command source plus MDR side.
interface mdr_host_sequencer_if #(
  parameter int unsigned DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_x;
  logic [DW-1:0] req_y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [DW-1:0] rsp_reminder;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          mdr_start;
  logic [1:0]    mdr_op;
  logic          mdr_load;
  logic [DW-1:0] mdr_data;
  logic          mdr_load_x;
  logic          mdr_load_y;
  logic          mdr_ready;
  logic          mdr_error;
  logic [DW-1:0] mdr_result;
  logic [DW-1:0] mdr_reminder;

  modport master (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    input  mdr_load_x, mdr_load_y, mdr_ready, mdr_error, mdr_result, mdr_reminder,
    output req_ready, rsp_valid, rsp_result, rsp_reminder, rsp_error, rsp_timeout,
    output mdr_start, mdr_op, mdr_load, mdr_data
  );

  modport slave (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    output mdr_load_x, mdr_load_y, mdr_ready, mdr_error, mdr_result, mdr_reminder,
    input  req_ready, rsp_valid, rsp_result, rsp_reminder, rsp_error, rsp_timeout,
    input  mdr_start, mdr_op, mdr_load, mdr_data
  );
endinterface

// File: rtl/mdr_host_sequencer.sv
// Initiator-side sequencer for the MDR unit: takes one command, walks the MDR
// operand-loading protocol, and returns the captured result with a timeout watchdog.
module mdr_host_sequencer #(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mdr_host_sequencer_if.master bus
);

  localparam int unsigned   CW        = $clog2(TIMEOUT + 32'd2);
  localparam int unsigned   TO_LAST   = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;
  localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);
  localparam logic [1:0]    OP_SQRT   = 2'b10;
  localparam logic [1:0]    OP_ILL    = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_WAIT_LX  = 4'd2,
    S_LOAD_X   = 4'd3,
    S_GAP_X    = 4'd4,
    S_WAIT_LY  = 4'd5,
    S_LOAD_Y   = 4'd6,
    S_GAP_Y    = 4'd7,
    S_WAIT_RDY = 4'd8,
    S_RESP     = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_result_q, rsp_result_d;
  logic [DW-1:0] rsp_reminder_q, rsp_reminder_d;
  logic          rsp_error_q, rsp_error_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          mdr_start_q, mdr_start_d;
  logic [1:0]    mdr_op_q, mdr_op_d;
  logic          mdr_load_q, mdr_load_d;
  logic [DW-1:0] mdr_data_q, mdr_data_d;
  logic          evt_s;
  logic          wd_hit_s;

  // Progress event awaited by the current WAIT state, and watchdog expiry.
  always_comb begin
    evt_s = 1'b0;
    case (state_q)
      S_WAIT_LX:  evt_s = bus.mdr_load_x;
      S_WAIT_LY:  evt_s = bus.mdr_load_y;
      S_WAIT_RDY: evt_s = bus.mdr_ready;
      default:    evt_s = 1'b0;
    endcase
    wd_hit_s = (TIMEOUT != 32'd0) && (cnt_q == TO_LAST_C);
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    x_d            = x_q;
    y_d            = y_q;
    cnt_d          = {CW{1'b0}};
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_reminder_d = rsp_reminder_q;
    rsp_error_d    = rsp_error_q;
    rsp_timeout_d  = rsp_timeout_q;
    mdr_op_d       = mdr_op_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d = bus.req_op;
          x_d  = bus.req_x;
          y_d  = bus.req_y;
          if (bus.req_op == OP_ILL) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d  = S_START;
            mdr_op_d = bus.req_op;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: state_d = S_WAIT_LX;
      S_WAIT_LX, S_WAIT_LY, S_WAIT_RDY: begin
        // Error wins over any simultaneous progress event or watchdog expiry.
        if (bus.mdr_error) begin
          state_d        = S_RESP;
          rsp_valid_d    = 1'b1;
          rsp_error_d    = 1'b1;
          rsp_result_d   = {DW{1'b0}};
          rsp_reminder_d = {DW{1'b0}};
        end else if (evt_s) begin
          case (state_q)
            S_WAIT_LX: state_d = S_LOAD_X;
            S_WAIT_LY: state_d = S_LOAD_Y;
            default: begin
              state_d        = S_RESP;
              rsp_valid_d    = 1'b1;
              rsp_error_d    = 1'b0;
              rsp_result_d   = bus.mdr_result;
              rsp_reminder_d = bus.mdr_reminder;
            end
          endcase
        end else if (wd_hit_s) begin
          state_d        = S_RESP;
          rsp_valid_d    = 1'b1;
          rsp_timeout_d  = 1'b1;
          rsp_error_d    = 1'b0;
          rsp_result_d   = {DW{1'b0}};
          rsp_reminder_d = {DW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOAD_X: state_d = S_GAP_X;
      S_GAP_X: begin
        if (op_q == OP_SQRT) begin
          state_d = S_WAIT_RDY;
        end else begin
          state_d = S_WAIT_LY;
        end
      end
      S_LOAD_Y: state_d = S_GAP_Y;
      S_GAP_Y:  state_d = S_WAIT_RDY;
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d        = S_IDLE;
          rsp_valid_d    = 1'b0;
          rsp_result_d   = {DW{1'b0}};
          rsp_reminder_d = {DW{1'b0}};
          rsp_error_d    = 1'b0;
          rsp_timeout_d  = 1'b0;
          mdr_op_d       = 2'b00;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    mdr_start_d = (state_d == S_START);
    mdr_load_d  = (state_d == S_LOAD_X) || (state_d == S_LOAD_Y);
    case (state_d)
      S_LOAD_X, S_GAP_X: mdr_data_d = x_q;
      S_LOAD_Y, S_GAP_Y: mdr_data_d = y_q;
      default:           mdr_data_d = {DW{1'b0}};
    endcase
  end

  // State, captured command, watchdog and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= 2'b00;
      x_q            <= {DW{1'b0}};
      y_q            <= {DW{1'b0}};
      cnt_q          <= {CW{1'b0}};
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= {DW{1'b0}};
      rsp_reminder_q <= {DW{1'b0}};
      rsp_error_q    <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      mdr_start_q    <= 1'b0;
      mdr_op_q       <= 2'b00;
      mdr_load_q     <= 1'b0;
      mdr_data_q     <= {DW{1'b0}};
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      x_q            <= x_d;
      y_q            <= y_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_reminder_q <= rsp_reminder_d;
      rsp_error_q    <= rsp_error_d;
      rsp_timeout_q  <= rsp_timeout_d;
      mdr_start_q    <= mdr_start_d;
      mdr_op_q       <= mdr_op_d;
      mdr_load_q     <= mdr_load_d;
      mdr_data_q     <= mdr_data_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_reminder = rsp_reminder_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign bus.mdr_start    = mdr_start_q;
  assign bus.mdr_op       = mdr_op_q;
  assign bus.mdr_load     = mdr_load_q;
  assign bus.mdr_data     = mdr_data_q;

endmodule

// File: tb/tb_mdr_host_sequencer.sv
// Bench for mdr_host_sequencer: behavioural MDR model, directed scenarios from
// the test plan, then randomized commands checked against an arithmetic reference.
module tb_mdr_host_sequencer;
  localparam int unsigned DW  = 16;
  localparam int unsigned DW2 = 2 * DW;
  localparam int unsigned TO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdr_host_sequencer_if #(.DW(DW)) bus ();
  mdr_host_sequencer #(.DW(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: {error, reminder, result} of an MDR operation.
  function automatic logic [DW2:0] ref_calc(input logic [1:0] op, input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
    logic [DW2-1:0] p;
    int unsigned s;
    ref_calc = '0;
    case (op)
      2'b00: begin
        p = DW2'(x) * DW2'(y);
        ref_calc = {1'b0, p};
      end
      2'b01: begin
        if (y == '0) ref_calc = {1'b1, {DW2{1'b0}}};
        else ref_calc = {1'b0, DW'(x % y), DW'(x / y)};
      end
      2'b10: begin
        s = 0;
        for (int unsigned r = 0; r <= 256; r++) if (r * r <= 32'(x)) s = r;
        ref_calc = {1'b0, DW'(32'(x) - s * s), DW'(s)};
      end
      default: ref_calc = {1'b1, {DW2{1'b0}}};
    endcase
  endfunction

  // MDR model: phase 1 wants X, 2 wants Y, 3 computing/done; random response delays.
  logic           hi_mode = 1'b1;
  logic           mute_lx = 1'b0;
  int             max_dly = 0;
  logic [1:0]     m_op = 2'b00;
  logic [DW-1:0]  m_x = '0;
  logic [DW-1:0]  m_y = '0;
  int             m_phase = 0;
  int             m_dly = 0;
  logic [DW2:0]   m_calc;
  logic           m_go;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_dly   <= 0;
    end else begin
      if (m_dly != 0) m_dly <= m_dly - 1;
      if (bus.mdr_start) begin
        m_op    <= bus.mdr_op;
        m_phase <= 1;
        m_dly   <= int'($urandom_range(max_dly, 0));
      end else if (bus.mdr_load && m_phase == 1) begin
        m_x     <= bus.mdr_data;
        m_phase <= (m_op == 2'b10) ? 3 : 2;
        m_dly   <= int'($urandom_range(max_dly, 0));
      end else if (bus.mdr_load && m_phase == 2) begin
        m_y     <= bus.mdr_data;
        m_phase <= 3;
        m_dly   <= int'($urandom_range(max_dly, 0));
      end
    end
  end

  always_comb m_calc = ref_calc(m_op, m_x, m_y);
  assign m_go             = hi_mode || (m_dly == 0);
  assign bus.mdr_load_x   = !mute_lx && (m_phase == 1) && m_go;
  assign bus.mdr_load_y   = (m_phase == 2) && m_go;
  assign bus.mdr_ready    = (m_phase == 3) && m_go && !m_calc[DW2];
  assign bus.mdr_error    = (m_phase == 3) && m_go && m_calc[DW2];
  assign bus.mdr_result   = m_calc[DW2] ? {DW{1'b1}} : m_calc[DW-1:0];
  assign bus.mdr_reminder = m_calc[DW2] ? {DW{1'b1}} : m_calc[DW2-1:DW];

  // Bus monitor: pulse counts, load data log, start/load overlap and back-to-back loads.
  int            n_start = 0;
  int            n_load  = 0;
  int            n_viol  = 0;
  logic          prev_load = 1'b0;
  logic [DW-1:0] load_log [0:255];

  always @(posedge clk) begin
    if (rst) begin
      prev_load <= 1'b0;
    end else begin
      if (bus.mdr_start) n_start <= n_start + 1;
      if (bus.mdr_load) begin
        load_log[n_load[7:0]] <= bus.mdr_data;
        n_load <= n_load + 1;
      end
      if (bus.mdr_load && (prev_load || bus.mdr_start)) n_viol <= n_viol + 1;
      prev_load <= bus.mdr_load;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One command through to a completed response; exp_lat 0 skips the latency check.
  task automatic run_txn(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input int hold, input bit pre_ready, input int exp_lat, input bit exp_to);
    int k, s0, l0, exp_loads;
    logic [DW2:0] e;
    logic [DW-1:0] er, em;
    logic ee;
    e = ref_calc(op, x, y);
    if (exp_to) begin
      er = '0; em = '0; ee = 1'b0; exp_loads = 0;
    end else begin
      ee = e[DW2]; er = e[DW-1:0]; em = e[DW2-1:DW];
      exp_loads = (op == 2'b11) ? 0 : (op == 2'b10) ? 1 : 2;
    end
    @(negedge clk);
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    s0 = n_start;
    l0 = n_load;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.rsp_ready = pre_ready;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 1;
    while (bus.rsp_valid !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("rsp_valid_rise", 64'(bus.rsp_valid), 64'd1);
    if (exp_lat > 0) check("latency", 64'(k), 64'(exp_lat));
    check("rsp_result", 64'(bus.rsp_result), 64'(er));
    check("rsp_reminder", 64'(bus.rsp_reminder), 64'(em));
    check("rsp_error", 64'(bus.rsp_error), 64'(ee));
    check("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_result", 64'(bus.rsp_result), 64'(er));
      check("hold_reminder", 64'(bus.rsp_reminder), 64'(em));
      check("hold_req_ready", 64'(bus.req_ready), 64'd0);
      check("hold_mdr_op", 64'(bus.mdr_op), (op == 2'b11) ? 64'd0 : 64'(op));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("post_valid", 64'(bus.rsp_valid), 64'd0);
    check("post_result", 64'(bus.rsp_result), 64'd0);
    check("post_flags", 64'({bus.rsp_error, bus.rsp_timeout}), 64'd0);
    check("post_mdr_op", 64'(bus.mdr_op), 64'd0);
    check("post_req_ready", 64'(bus.req_ready), 64'd1);
    check("start_count", 64'(n_start - s0), (op == 2'b11) ? 64'd0 : 64'd1);
    check("load_count", 64'(n_load - l0), 64'(exp_loads));
    if (exp_loads >= 1) check("load_x_data", 64'(load_log[l0[7:0]]), 64'(x));
    if (exp_loads == 2) check("load_y_data", 64'(load_log[8'(l0 + 1)]), 64'(y));
  endtask

  initial begin
    logic       seen;
    logic [1:0] rop;
    int         rhold;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}), 64'd0);
    check("rst_rsp_data", 64'({bus.rsp_result, bus.rsp_reminder}), 64'd0);
    check("rst_mdr_ctl", 64'({bus.mdr_start, bus.mdr_load, bus.mdr_op}), 64'd0);
    check("rst_mdr_data", 64'(bus.mdr_data), 64'd0);
    rst = 1'b0;

    run_txn(2'b00, 16'd250, 16'd200, 0, 1'b1, 9, 1'b0);
    run_txn(2'b01, 16'd100, 16'd7, 5, 1'b0, 9, 1'b0);
    run_txn(2'b10, 16'd50, 16'd0, 0, 1'b0, 6, 1'b0);

    hi_mode = 1'b0;
    max_dly = 3;
    run_txn(2'b01, 16'd1234, 16'd0, 1, 1'b0, 0, 1'b0);
    run_txn(2'b11, 16'd5, 16'd6, 1, 1'b0, 1, 1'b0);
    mute_lx = 1'b1;
    run_txn(2'b00, 16'd9, 16'd9, 0, 1'b0, 10, 1'b1);
    mute_lx = 1'b0;

    // Abort a mult in LOAD_Y with an asynchronous reset.
    hi_mode = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_x     = 16'd7;
    bus.req_y     = 16'd9;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("loady_pulse", 64'(bus.mdr_load), 64'd1);
    check("loady_data", 64'(bus.mdr_data), 64'd9);
    #2 rst = 1'b1;
    #1;
    check("arst_mdr_ctl", 64'({bus.mdr_start, bus.mdr_load, bus.mdr_op}), 64'd0);
    check("arst_mdr_data", 64'(bus.mdr_data), 64'd0);
    check("arst_req_ready", 64'(bus.req_ready), 64'd1);
    check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", 64'(seen), 64'd0);
    run_txn(2'b00, 16'd3, 16'd4, 0, 1'b0, 9, 1'b0);

    hi_mode = 1'b0;
    max_dly = 5;
    for (int t = 0; t < 20; t++) begin
      rop   = 2'($urandom_range(3, 0));
      rhold = int'($urandom_range(3, 0));
      run_txn(rop, 16'($urandom), ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom),
              rhold, (rhold == 0) ? 1'($urandom_range(1, 0)) : 1'b0, 0, 1'b0);
    end

    check("protocol_violations", 64'(n_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdr_host_sequencer.md
# mdr_host_sequencer

Initiator-side sequencer for the multiply/divide/square-root (MDR) unit. It accepts one command (op, X, Y) on a valid/ready request port and drives the MDR operand-loading protocol: Start, Op, Load pulses, and Data in response to Load_X/Load_Y. It then captures Result/Reminder on Ready or error and returns them on a valid/ready response port. It sits between a bus-side command source and the MDR top and owns a timeout watchdog.

## Interface
- DW, 16, operand/result width (matches MDR `DW`)
- TIMEOUT, 1024, max cycles spent in any WAIT state before abort; 0 disables the watchdog
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  high only in IDLE
- req_op  in  2  00 mult, 01 div, 10 sqrt, 11 illegal
- req_x, req_y  in  DW  operands (req_y ignored for sqrt)
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_result, rsp_reminder  out  DW  captured MDR outputs
- rsp_error  out  1  MDR error or illegal op
- rsp_timeout  out  1  watchdog abort
- mdr_start  out  1  one-cycle Start pulse
- mdr_op  out  2  op held for the whole transaction
- mdr_load  out  1  one-cycle Load pulse per operand
- mdr_data  out  DW  operand, driven during LOAD and GAP, else 0
- mdr_load_x, mdr_load_y, mdr_ready, mdr_error  in  1  MDR status
- mdr_result, mdr_reminder  in  DW  MDR outputs

## Operation
- States: IDLE, START, WAIT_LX, LOAD_X, GAP_X, WAIT_LY, LOAD_Y, GAP_Y, WAIT_RDY, RESP.
- IDLE: req_ready=1. On req_valid, capture op/x/y.
  - Op 11 → RESP with rsp_error=1 and result/reminder 0. No MDR activity.
  - Otherwise → START.
- START: mdr_start=1 for one cycle, mdr_op=op → WAIT_LX.
- WAIT_LX: on mdr_load_x=1 → LOAD_X.
- LOAD_X: mdr_data=x, mdr_load=1 → GAP_X.
- GAP_X: mdr_data=x, mdr_load=0. The guaranteed low cycle is needed by the MDR one-shot.
  - Sqrt → WAIT_RDY.
  - Else → WAIT_LY.
- WAIT_LY/LOAD_Y/GAP_Y: same as the X states, using y → WAIT_RDY.
- WAIT_RDY: on mdr_ready=1, capture mdr_result/mdr_reminder, rsp_error=0 → RESP.
- mdr_error=1 sampled in any WAIT state: capture rsp_error=1, result/reminder 0 → RESP. Error has priority over a simultaneous load_x/load_y/ready.
- Watchdog: counter clears on entry to each WAIT state and increments each cycle in it. Reaching TIMEOUT with no event → RESP with rsp_timeout=1, rsp_error=0, result/reminder 0.
- RESP: rsp_valid=1 with fields stable.
  - When rsp_ready=1 → IDLE. mdr_op returns to 0 and response fields clear.
  - rsp_ready=1 in the same cycle rsp_valid rises completes the handshake in that cycle.
- The next command is not accepted until the cycle after RESP exits (no overlap).
- Inputs are sampled on clk with no synchronizer; the MDR shares clk.

## Timing
- Reset (async assert, sync release): state=IDLE; req_ready=1.
  - All other outputs (rsp_valid, rsp_result, rsp_reminder, rsp_error, rsp_timeout, mdr_start, mdr_op, mdr_load, mdr_data) = 0. Counter=0.
- Reset mid-transaction: immediately returns to IDLE, drops mdr_start/mdr_load, and produces no response.
- Accept at cycle N with load_x/load_y/ready already high (mult/div):
  - START at N+1, LOAD_X at N+3, LOAD_Y at N+6, WAIT_RDY at N+8, rsp_valid at N+9. Minimum total is 9 cycles.
- Sqrt minimum: rsp_valid at N+6.
- Illegal op: rsp_valid at N+1.
- mdr_load is high exactly one cycle per operand and is always followed by at least one low cycle.
- mdr_start is never high in the same cycle as mdr_load.

## Test plan
- Mult x=250, y=200 with a responsive MDR model → exactly one mdr_start pulse and two mdr_load pulses (data 250 then 200). Response: rsp_result=50000, rsp_error=0, rsp_valid at accept+9.
- Div x=100, y=7 → rsp_result=14, rsp_reminder=2. Hold rsp_ready=0 for 5 cycles: rsp_valid and fields stay stable, and req_ready stays 0.
- Sqrt x=50 → one mdr_load pulse only, rsp_result=7, rsp_reminder=1, rsp_valid at accept+6.
- Div y=0 with the model raising mdr_error in WAIT_RDY → rsp_error=1, result 0. req_op=11 → rsp_error=1 at accept+1 with mdr_start never asserted.
- TIMEOUT=8 with the model never raising mdr_load_x → rsp_timeout=1 eight cycles after WAIT_LX entry, rsp_error=0.
- Assert rst during LOAD_Y → all outputs at reset values asynchronously, no rsp_valid. A following mult 3×4 completes with rsp_result=12.
